// File: rtl/booth_arb_pkg.sv
// Shared widths and FSM state encoding for the Booth multiplier arbiter.
package booth_arb_pkg;

    localparam int MUL_W  = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Request/response bundle between the client blocks and the shared multiplier arbiter.
interface booth_mul_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import booth_arb_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*MUL_W-1:0] req_a;
    logic [NUM_REQ*MUL_W-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [PROD_W-1:0]        rsp_prod;
    logic [ID_W-1:0]          rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_prod, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_prod, rsp_id
    );

endinterface

// File: rtl/booth_rr_picker.sv
// Round-robin winner selection: first valid requester at or after rr_ptr, wrapping.
module booth_rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W:0] scan;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            scan = {1'b0, rr_ptr} + (ID_W+1)'(off);
            if (scan >= (ID_W+1)'(NUM_REQ)) begin
                scan = scan - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[scan[ID_W-1:0]]) begin
                found                   = 1'b1;
                grant[scan[ID_W-1:0]]   = 1'b1;
                grant_idx               = scan[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/modifiedBooth.sv
// Combinational radix-4 Booth multiplier, 4-bit x 4-bit unsigned -> 8-bit product.
module modifiedBooth (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [6:0] bx;
    logic [7:0] a_ext;
    logic [7:0] pp;
    logic [7:0] acc;

    // Zero-extend b by two bits so the top digit absorbs b[3] as an unsigned weight;
    // the sum is kept mod 256, which is exact because the true product fits in 8 bits.
    always_comb begin
        bx    = {2'b00, b, 1'b0};
        a_ext = {4'b0000, a};
        acc   = '0;
        pp    = '0;
        for (int i = 0; i < 3; i++) begin
            case (bx[2*i +: 3])
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = -(a_ext << 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * i));
        end
        p = acc;
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier; operands and product are registered
// around the multiplier and each product is returned tagged with its requester index.
//
//  state | meaning
//  IDLE  | offer req_ready to the round-robin winner, latch its operands on handshake
//  CALC  | multiplier evaluates op_a*op_b; result and id registered into the response
//  RESP  | hold response until rsp_ready, then advance rr_ptr past the served requester
module booth_mul_arbiter
    import booth_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic clk,
    input  logic rst,
    booth_mul_arbiter_if.slave bus,
    output logic busy
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    next_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [MUL_W-1:0]   op_a;
    logic [MUL_W-1:0]   op_b;
    logic [MUL_W-1:0]   sel_a;
    logic [MUL_W-1:0]   sel_b;
    logic [PROD_W-1:0]  prod;
    logic [PROD_W-1:0]  rsp_prod_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic               rsp_valid_q;
    logic               handshake;

    booth_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    modifiedBooth u_mul (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    // The picker only ever grants a valid requester, so an offered grant is a handshake.
    assign bus.req_ready = (state == ST_IDLE) ? grant : '0;
    assign handshake     = (state == ST_IDLE) && (|grant);
    assign sel_a         = bus.req_a[grant_idx*MUL_W +: MUL_W];
    assign sel_b         = bus.req_b[grant_idx*MUL_W +: MUL_W];
    assign next_ptr      = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_prod  = rsp_prod_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            id_q        <= '0;
            op_a        <= '0;
            op_b        <= '0;
            rsp_prod_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        id_q  <= grant_idx;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    rsp_prod_q  <= prod;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr      <= next_ptr;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter: directed requests push expected {id, product},
// a negedge monitor pops and compares on every response handshake.
module tb_booth_mul_arbiter;
    import booth_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [7:0]      prod;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    exp_t       exp_q[$];
    logic [7:0] pend[NUM_REQ][$];
    int         pop_cyc[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    exp_t       mon_e;

    always #5 clk = ~clk;

    booth_mul_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

    booth_mul_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic req(input int id, input logic [3:0] a, input logic [3:0] b, input logic [7:0] p);
        exp_t e;
        e.id   = ID_W'(id);
        e.prod = p;
        pend[id].push_back({a, b});
        exp_q.push_back(e);
    endtask

    function automatic int pend_cnt();
        int n = 0;
        for (int i = 0; i < NUM_REQ; i++) n += pend[i].size();
        return n;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || pend_cnt() > 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d responses still outstanding after %0d cycles, expected 0",
                     name, exp_q.size(), budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Requester model: holds valid and data steady until its handshake, then presents the next item.
    initial begin
        logic [NUM_REQ-1:0] hs;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        forever begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i] && pend[i].size() > 0) pend[i].delete(0);
                bus.req_valid[i] = (pend[i].size() > 0);
                if (pend[i].size() > 0) begin
                    bus.req_a[i*4 +: 4] = pend[i][0][7:4];
                    bus.req_b[i*4 +: 4] = pend[i][0][3:0];
                end
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got id %0d prod %0h, expected no response",
                             bus.rsp_id, bus.rsp_prod);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
                    chk("rsp_prod", 32'(bus.rsp_prod), 32'(mon_e.prod));
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        int n;
        rst           = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_prod",  32'(bus.rsp_prod),  32'd0);
        chk("reset_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("reset_busy",      32'(busy),          32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_rr_ptr",    32'(dut.rr_ptr),    32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request from requester 2: 3*5.
        req(2, 4'd3, 4'd5, 8'h0F);
        @(negedge clk);
        chk("single_req_ready", 32'(bus.req_ready), 32'b0100);
        chk("single_busy_n",    32'(busy),          32'd0);
        @(negedge clk);
        chk("single_busy_calc", 32'(busy),          32'd1);
        chk("single_valid_n1",  32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("single_valid_n2",  32'(bus.rsp_valid), 32'd1);
        chk("single_busy_resp", 32'(busy),          32'd1);
        @(negedge clk);
        chk("single_busy_done", 32'(busy),          32'd0);
        drain("single", 20);

        // All four requesters continuously valid from rr_ptr=0.
        do_reset();
        pop_cyc.delete();
        req(0, 4'd1, 4'd2, 8'd2);
        req(1, 4'd2, 4'd3, 8'd6);
        req(2, 4'd4, 4'd5, 8'd20);
        req(3, 4'd6, 4'd7, 8'd42);
        req(0, 4'd7, 4'd9, 8'd63);
        drain("all4", 60);
        chk("all4_count", 32'(pop_cyc.size()), 32'd5);
        if (pop_cyc.size() == 5) begin
            for (int i = 1; i < 5; i++) chk("all4_interval", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd3);
        end

        // Backpressure with another requester waiting.
        bus.rsp_ready = 1'b0;
        req(1, 4'hF, 4'hF, 8'hE1);
        req(0, 4'h1, 4'h1, 8'h01);
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("stall_rsp_seen", 32'(bus.rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_rsp_prod",  32'(bus.rsp_prod),  32'hE1);
            chk("stall_rsp_id",    32'(bus.rsp_id),    32'd1);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        drain("stall", 30);

        // Only 3 and 0 valid: grants 3, 0, 3 with rr_ptr wrapping after each grant to 3.
        req(3, 4'd2, 4'd2, 8'd4);
        req(0, 4'd5, 4'd5, 8'h19);
        req(3, 4'd3, 4'd3, 8'd9);
        drain("wrap", 40);
        chk("wrap_rr_ptr", 32'(dut.rr_ptr), 32'd0);

        // Reset while in CALC.
        req(1, 4'd2, 4'd2, 8'd4);
        drain("pre_rst", 20);
        chk("pre_rst_rr_ptr", 32'(dut.rr_ptr), 32'd2);
        req(2, 4'd9, 4'd9, 8'h51);
        n = 0;
        while (!bus.req_ready[2] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_grant", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        chk("midrst_in_calc", 32'(busy), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_busy",      32'(busy),          32'd0);
        chk("midrst_rr_ptr",    32'(dut.rr_ptr),    32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", 32'(bus.rsp_valid), 32'd0);
        end

        // Exhaustive operand sweep through requester 1.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                req(1, 4'(a), 4'(b), 8'(a * b));
            end
        end
        req(1, 4'h8, 4'h8, 8'h40);
        req(1, 4'hF, 4'hF, 8'hE1);
        req(1, 4'h0, 4'hF, 8'h00);
        drain("sweep", 1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
